// File: rtl/pipelined_add_sub.sv
// Pipelined WIDTH-bit adder/subtractor, one CW-bit ripple chunk per stage,
// with skewed operands, deskewed results and a valid/ready handshake.
module pipelined_add_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    generate
        if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
            $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
        end
    endgenerate

    logic             stall;
    logic             en;

    logic             v_q   [STAGES];
    logic             sub_q [STAGES];
    logic             c_q   [STAGES];
    logic [WIDTH-1:0] x_q   [STAGES];
    logic [WIDTH-1:0] y_q   [STAGES];
    logic             msbc_q;
    logic             zero_q;

    logic             v_d   [STAGES];
    logic             sub_d [STAGES];
    logic             c_d   [STAGES];
    logic [WIDTH-1:0] x_d   [STAGES];
    logic [WIDTH-1:0] y_d   [STAGES];

    logic             c_n   [STAGES];
    logic [WIDTH-1:0] x_n   [STAGES];
    logic             msbc_n;
    logic             zero_n;

    assign stall    = v_q[LAST] & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;

    // x carries finished result chunks below the current chunk and A above it
    always_comb begin
        x_d[0]   = a;
        y_d[0]   = sub ? ~b : b;
        c_d[0]   = cin ^ sub;
        v_d[0]   = in_valid;
        sub_d[0] = sub;
        for (int k = 1; k < STAGES; k++) begin
            x_d[k]   = x_q[k-1];
            y_d[k]   = y_q[k-1];
            c_d[k]   = c_q[k-1];
            v_d[k]   = v_q[k-1];
            sub_d[k] = sub_q[k-1];
        end
    end

    always_comb begin
        logic c;
        int   j;
        c      = 1'b0;
        j      = 0;
        x_n    = x_d;
        c_n    = c_d;
        msbc_n = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            c = c_d[k];
            for (int i = 0; i < CW; i++) begin
                j = k * CW + i;
                if (j == WIDTH - 1) begin
                    msbc_n = c;
                end
                x_n[k][j] = x_d[k][j] ^ y_d[k][j] ^ c;
                c = (x_d[k][j] & y_d[k][j]) | (c & (x_d[k][j] ^ y_d[k][j]));
            end
            c_n[k] = c;
        end
        zero_n = ~|x_n[LAST];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= 1'b0;
                sub_q[k] <= 1'b0;
                c_q[k]   <= 1'b0;
                x_q[k]   <= '0;
                y_q[k]   <= '0;
            end
            msbc_q <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]   <= v_d[k];
                sub_q[k] <= sub_d[k];
                c_q[k]   <= c_n[k];
                x_q[k]   <= x_n[k];
                y_q[k]   <= y_d[k];
            end
            msbc_q <= msbc_n;
            zero_q <= zero_n;
        end
    end

    // Borrow is the inverted final carry in subtract mode
    assign out_valid = v_q[LAST];
    assign s         = x_q[LAST];
    assign cout      = c_q[LAST] ^ sub_q[LAST];
    assign ovf       = c_q[LAST] ^ msbc_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: 8/2 vector table plus a 32/4 instance
// driven by random, backpressure and reset sequences against a model.
module tb_pipelined_add_sub;

    typedef struct {
        logic [31:0] s;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct {
        res_t r;
        int   t;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic       cout;
        logic       ovf;
        logic       zero;
    } vec_t;

    logic clk;
    logic rst_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, s;
    logic        cin, sub, cout, ovf, zero;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0] a8, b8, s8;
    logic       cin8, sub8, cout8, ovf8, zero8;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   lat_chk = 0;
    exp_t sb_q[$];

    logic        prev_stall = 0;
    logic [31:0] prev_s;
    logic        prev_cout, prev_ovf, prev_zero;

    pipelined_add_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf), .zero(zero)
    );

    pipelined_add_sub #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Arithmetic done on plain integers: unsigned for s/cout, signed for ovf
    function automatic res_t model(int w, logic [31:0] x, logic [31:0] y, logic ci, logic sb);
        longint m, ux, uy, sx, sy, r, sr;
        res_t   o;
        m  = longint'(1) << w;
        ux = longint'(x);
        uy = longint'(y);
        sx = x[w-1] ? ux - m : ux;
        sy = y[w-1] ? uy - m : uy;
        r  = sb ? ux - uy - longint'(ci) : ux + uy + longint'(ci);
        sr = sb ? sx - sy - longint'(ci) : sx + sy + longint'(ci);
        o.s    = 32'(r & (m - 1));
        o.cout = sb ? (r < 0) : (r >= m);
        o.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        o.zero = ((r & (m - 1)) == 0);
        return o;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst_n) begin
            sb_q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_s", s, prev_s);
                check("hold_cout", cout, prev_cout);
                check("hold_ovf", ovf, prev_ovf);
                check("hold_zero", zero, prev_zero);
            end
            if (out_valid && !out_ready)
                check("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got s=%0h expected no result", s);
                end else begin
                    e = sb_q.pop_front();
                    check("s", s, e.r.s);
                    check("cout", cout, e.r.cout);
                    check("ovf", ovf, e.r.ovf);
                    check("zero", zero, e.r.zero);
                    if (lat_chk) check("latency", cyc - e.t, 3);
                end
            end
            if (in_valid && in_ready) begin
                e.r = model(32, a, b, cin, sub);
                e.t = cyc + 1;
                sb_q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_s     = s;
            prev_cout  = cout;
            prev_ovf   = ovf;
            prev_zero  = zero;
        end
    end

    task automatic send32(input logic [31:0] x, input logic [31:0] y, input logic ci, input logic sb);
        bit acc;
        acc      = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = ci;
        sub      = sb;
        for (int k = 0; k < 50 && !acc; k++) begin
            #1 acc = in_ready;
            @(negedge clk);
        end
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            if (sb_q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check("drain_empty", sb_q.size(), 0);
    endtask

    vec_t tbl[8];

    initial begin
        int base;
        logic [31:0] x, y;

        tbl[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
        tbl[6] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0};

        rst_n = 0;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
        in_valid8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; out_ready8 = 1;

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_s", s, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        check("rst_zero", zero, 0);
        check("rst_out_valid8", out_valid8, 0);
        @(negedge clk);
        #2 rst_n = 1;
        #1 check("rst_in_ready", in_ready, 1);
        check("rst_in_ready8", in_ready8, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            in_valid8 = 1'b1;
            a8   = tbl[i].a;
            b8   = tbl[i].b;
            cin8 = tbl[i].cin;
            sub8 = tbl[i].sub;
            @(negedge clk);
            in_valid8 = 1'b0;
            check("v8_early", out_valid8, 0);
            @(negedge clk);
            check("v8_valid", out_valid8, 1);
            check("v8_s", s8, tbl[i].s);
            check("v8_cout", cout8, tbl[i].cout);
            check("v8_ovf", ovf8, tbl[i].ovf);
            check("v8_zero", zero8, tbl[i].zero);
            @(negedge clk);
        end

        lat_chk = 1;
        for (int i = 0; i < 1000; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? x : $urandom;
            if ($urandom_range(0, 15) == 0) x = '1;
            send32(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 0;
        drain();
        lat_chk = 0;

        base = n_out;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send32($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                in_valid = 0;
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 0;
                repeat (3) @(negedge clk);
                out_ready = 1;
            end
        join
        drain();
        check("bp_count", n_out - base, 6);

        for (int i = 0; i < 3; i++)
            send32($urandom, $urandom, 1'b0, 1'($urandom_range(0, 1)));
        in_valid = 0;
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_s", s, 0);
        check("arst_cout", cout, 0);
        check("arst_ovf", ovf, 0);
        check("arst_zero", zero, 0);
        @(negedge clk);
        @(negedge clk);
        #3 rst_n = 1;
        #1 check("arst_in_ready", in_ready, 1);
        check("arst_queue", sb_q.size(), 0);
        base = n_out;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arst_no_stale", out_valid, 0);
        end
        check("arst_no_out", n_out - base, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
